// File: rtl/eco_sweep_pkg.sv
// Shared types and default widths for the ECO exhaustive-sweep checker.
package eco_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } sweep_state_t;

  localparam int DEF_WA = 5;
  localparam int DEF_WB = 5;
  localparam int DEF_WY = 3;
  localparam int NVEC   = 1 << (DEF_WA + DEF_WB);

endpackage

// File: rtl/eco_mismatch_tracker.sv
// Compares patched vs golden netlist outputs and accumulates sweep results.
import eco_sweep_pkg::*;

module eco_mismatch_tracker #(
  parameter int NV = DEF_WA + DEF_WB,
  parameter int WY = DEF_WY
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          sample_en,
  input  logic [NV-1:0] vec,
  input  logic [WY-1:0] y_impl,
  input  logic [WY-1:0] y_gold,
  output logic [NV:0]   mism_cnt,
  output logic [NV-1:0] first_fail_vec,
  output logic          first_fail_valid,
  output logic [WY-1:0] diff_mask
);

  logic [WY-1:0] xor_p0;
  logic          mism_p0;

  // Case inequality so an unknown netlist output is reported as a mismatch.
  assign xor_p0  = y_impl ^ y_gold;
  assign mism_p0 = (y_impl !== y_gold);

  // ---- stage p0 -> p1: result registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mism_cnt         <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
      diff_mask        <= '0;
    end else if (clear) begin
      mism_cnt         <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
      diff_mask        <= '0;
    end else if (sample_en && mism_p0) begin
      mism_cnt  <= mism_cnt + 1'b1;
      diff_mask <= diff_mask | xor_p0;
      if (!first_fail_valid) begin
        first_fail_vec   <= vec;
        first_fail_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/eco_sweep_checker.sv
// Exhaustive input sweep of an ECO netlist pair with per-vector settle time
// and pass/fail reporting.
import eco_sweep_pkg::*;

module eco_sweep_checker #(
  parameter int WA     = DEF_WA,
  parameter int WB     = DEF_WB,
  parameter int WY     = DEF_WY,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WA-1:0]    vec_a,
  output logic [WB-1:0]    vec_b,
  input  logic [WY-1:0]    y_impl,
  input  logic [WY-1:0]    y_gold,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WA+WB:0]   mism_cnt,
  output logic [WA+WB-1:0] first_fail_vec,
  output logic             first_fail_valid,
  output logic [WY-1:0]    diff_mask
);

  localparam int NV = WA + WB;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_RLD = SW'(SETTLE - 1);
  localparam logic [NV-1:0] LAST_VEC   = '1;

  sweep_state_t  state, state_nxt;
  logic [NV-1:0] vec;
  logic [SW-1:0] settle_cnt;
  logic          sample_edge;
  logic          last_vec;
  logic          clear;

  always_comb begin
    state_nxt   = state;
    sample_edge = 1'b0;
    clear       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    last_vec    = (vec == LAST_VEC);
    case (state)
      IDLE: begin
        if (start) begin
          clear     = 1'b1;
          state_nxt = SWEEP;
        end
      end
      SWEEP: begin
        busy        = 1'b1;
        sample_edge = (settle_cnt == '0);
        if (sample_edge && last_vec) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          clear     = 1'b1;
          state_nxt = SWEEP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p0 -> p1: FSM, vector and settle counters ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vec        <= '0;
      settle_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (clear) begin
        vec        <= '0;
        settle_cnt <= SETTLE_RLD;
      end else if (state == SWEEP) begin
        if (!sample_edge) begin
          settle_cnt <= settle_cnt - 1'b1;
        end else if (!last_vec) begin
          vec        <= vec + 1'b1;
          settle_cnt <= SETTLE_RLD;
        end
      end
    end
  end

  assign vec_a = vec[WA-1:0];
  assign vec_b = vec[NV-1:WA];
  assign pass  = done && (mism_cnt == '0);

  eco_mismatch_tracker #(
    .NV (NV),
    .WY (WY)
  ) u_tracker (
    .clk              (clk),
    .rst_n            (rst_n),
    .clear            (clear),
    .sample_en        (sample_edge),
    .vec              (vec),
    .y_impl           (y_impl),
    .y_gold           (y_gold),
    .mism_cnt         (mism_cnt),
    .first_fail_vec   (first_fail_vec),
    .first_fail_valid (first_fail_valid),
    .diff_mask        (diff_mask)
  );

endmodule

// File: tb/tb_eco_sweep_checker.sv
// Bench for eco_sweep_checker: table of fault patterns plus reset/settle sequences.
module tb_eco_sweep_checker;

  localparam int NVEC = eco_sweep_pkg::NVEC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start3 = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]  a1, b1, a3, b3;
  logic [2:0]  yi1, yg1, yi3, yg3;
  logic        busy1, done1, pass1, ffval1, busy3, done3, pass3, ffval3;
  logic [10:0] mism1, mism3;
  logic [9:0]  ffv1, ffv3;
  logic [2:0]  mask1, mask3;

  logic [2:0] fault [NVEC];
  logic [2:0] rand_fault [NVEC];

  int checks = 0;
  int errors = 0;

  function automatic logic [2:0] netlist_f(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = a + b;
    return s[2:0] ^ {a[4], b[3], a[1]};
  endfunction

  always_comb begin
    yi1 = netlist_f(a1, b1);
    yg1 = yi1 ^ fault[{b1, a1}];
    yi3 = netlist_f(a3, b3);
    yg3 = yi3;
  end

  eco_sweep_checker #(.WA(5), .WB(5), .WY(3), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_a(a1), .vec_b(b1),
    .y_impl(yi1), .y_gold(yg1), .busy(busy1), .done(done1), .pass(pass1),
    .mism_cnt(mism1), .first_fail_vec(ffv1), .first_fail_valid(ffval1),
    .diff_mask(mask1));

  eco_sweep_checker #(.WA(5), .WB(5), .WY(3), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .vec_a(a3), .vec_b(b3),
    .y_impl(yi3), .y_gold(yg3), .busy(busy3), .done(done3), .pass(pass3),
    .mism_cnt(mism3), .first_fail_vec(ffv3), .first_fail_valid(ffval3),
    .diff_mask(mask3));

  typedef struct {
    int          kind;
    logic [10:0] e_mism;
    logic [9:0]  e_ffv;
    logic        e_ffval;
    logic [2:0]  e_mask;
    logic        e_pass;
  } row_t;

  row_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_faults(input int kind);
    for (int v = 0; v < NVEC; v++) begin
      case (kind)
        1:       fault[v] = (v == 10'h155) ? 3'b010 : 3'b000;
        2:       fault[v] = 3'b111;
        3:       fault[v] = rand_fault[v];
        default: fault[v] = 3'b000;
      endcase
    end
  endtask

  // Sweep result derived directly from the list of faulty vectors.
  task automatic ref_model(output logic [10:0] cnt, output logic [9:0] ffv,
                           output logic ffval, output logic [2:0] mask);
    cnt = '0; ffv = '0; ffval = 1'b0; mask = '0;
    for (int v = 0; v < NVEC; v++) begin
      if (rand_fault[v] != 3'b000) begin
        cnt++;
        mask |= rand_fault[v];
        if (!ffval) begin
          ffv   = v[9:0];
          ffval = 1'b1;
        end
      end
    end
  endtask

  task automatic run_sweep1(input bit mid_start);
    int n;
    int bad;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_busy", busy1, 1);
    chk("start_done_low", done1, 0);
    chk("start_clears_cnt", mism1, 0);
    n = 0;
    bad = 0;
    while (!done1 && n < 1100) begin
      if ({b1, a1} != n[9:0]) bad++;
      if (mid_start) start = (n == 500);
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    chk("sweep_len", n, 1024);
    chk("vec_sequence", bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [10:0] rc;
    logic [9:0]  rf;
    logic        rv;
    logic [2:0]  rm;
    int n;
    int bad;
    int q;

    for (int v = 0; v < NVEC; v++)
      rand_fault[v] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
    rand_fault[$urandom_range(0, NVEC - 1)] = 3'b100;
    ref_model(rc, rf, rv, rm);

    tbl[0] = '{0, 11'd0,    10'h000, 1'b0, 3'b000, 1'b1};
    tbl[1] = '{1, 11'd1,    10'h155, 1'b1, 3'b010, 1'b0};
    tbl[2] = '{2, 11'd1024, 10'h000, 1'b1, 3'b111, 1'b0};
    tbl[3] = '{3, rc,       rf,      rv,   rm,     1'b0};
    tbl[4] = '{0, 11'd0,    10'h000, 1'b0, 3'b000, 1'b1};

    load_faults(0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_pass", pass1, 0);
    chk("rst_cnt", mism1, 0);
    chk("rst_vec", {b1, a1}, 0);
    chk("rst_ffvalid", ffval1, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Row 3 also pulses start mid-sweep; row 4 restarts from DONE after a failing run.
    for (int r = 0; r < 5; r++) begin
      load_faults(tbl[r].kind);
      run_sweep1(r == 3);
      chk($sformatf("row%0d_mism", r), mism1, tbl[r].e_mism);
      chk($sformatf("row%0d_ffv", r), ffv1, tbl[r].e_ffv);
      chk($sformatf("row%0d_ffval", r), ffval1, tbl[r].e_ffval);
      chk($sformatf("row%0d_mask", r), mask1, tbl[r].e_mask);
      chk($sformatf("row%0d_pass", r), pass1, tbl[r].e_pass);
      chk($sformatf("row%0d_busy", r), busy1, 0);
      repeat (4) @(posedge clk);
      #1;
      chk($sformatf("row%0d_hold_done", r), done1, 1);
      chk($sformatf("row%0d_hold_vec", r), {b1, a1}, 10'h3ff);
      chk($sformatf("row%0d_hold_mism", r), mism1, tbl[r].e_mism);
    end

    // Reset in the middle of a sweep with five mismatches already counted.
    load_faults(0);
    fault[10] = 3'b001; fault[20] = 3'b001; fault[30] = 3'b001;
    fault[40] = 3'b001; fault[50] = 3'b001; fault[600] = 3'b100;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while ({b1, a1} != 10'd300 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("mid_reach_300", n, 300);
    chk("mid_cnt_before_rst", mism1, 5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy1, 0);
    chk("mid_rst_done", done1, 0);
    chk("mid_rst_cnt", mism1, 0);
    chk("mid_rst_ffvalid", ffval1, 0);
    chk("mid_rst_ffv", ffv1, 0);
    chk("mid_rst_mask", mask1, 0);
    chk("mid_rst_vec", {b1, a1}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep1(1'b0);
    chk("rerun_mism", mism1, 6);
    chk("rerun_ffv", ffv1, 10);
    chk("rerun_mask", mask1, 3'b101);
    chk("rerun_pass", pass1, 0);

    // Each vector held for three cycles on the SETTLE=3 instance.
    @(negedge clk);
    start3 = 1'b1;
    @(posedge clk);
    #1;
    start3 = 1'b0;
    n = 0;
    bad = 0;
    while (!done3 && n < 3200) begin
      q = n / 3;
      if ({b3, a3} != q[9:0]) bad++;
      @(posedge clk);
      #1;
      n++;
    end
    chk("s3_sweep_len", n, 3072);
    chk("s3_vec_hold", bad, 0);
    chk("s3_pass", pass3, 1);
    chk("s3_mism", mism3, 0);
    chk("s3_last_vec", {b3, a3}, 10'h3ff);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eco_sweep_checker.md
Name: eco_sweep_checker

Overview:
- Sequential harness stage that sits upstream and downstream of a combinational ECO test netlist (5-bit A, 5-bit B, 3-bit Y).
- Sweeps all 2^(WA+WB) input vectors into the netlist, holding each vector for SETTLE cycles.
- Samples the patched netlist output against a golden-netlist output driven by the same vector.
- Reports pass/fail, mismatch count, first failing vector and a sticky per-bit difference mask.

Parameters:
- WA, 5, width of vec_a (netlist input A)
- WB, 5, width of vec_b (netlist input B)
- WY, 3, width of compared outputs
- SETTLE, 1, cycles each vector is held before sampling (>=1)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a sweep; sampled in IDLE or DONE only
- vec_a  out  WA  drives netlist A; equals vec[WA-1:0]
- vec_b  out  WB  drives netlist B; equals vec[WA+WB-1:WA]
- y_impl  in  WY  output of the ECO-patched netlist (combinational from vec_a/vec_b)
- y_gold  in  WY  output of the golden netlist for the same vector
- busy  out  1  high while sweeping
- done  out  1  high from sweep completion until the next start or reset
- pass  out  1  done && mism_cnt==0; 0 otherwise
- mism_cnt  out  WA+WB+1  number of mismatching vectors
- first_fail_vec  out  WA+WB  first vector that mismatched
- first_fail_valid  out  1  first_fail_vec holds a captured vector
- diff_mask  out  WY  OR over all samples of (y_impl ^ y_gold)

Behaviour:
- Reset (async assert, sync release): state=IDLE, vec=0, settle_cnt=0, all outputs 0.
- FSM states: IDLE, SWEEP, DONE.
- IDLE/DONE with start=1:
  - next state SWEEP; vec=0, settle_cnt=SETTLE-1.
  - mism_cnt, first_fail_vec, first_fail_valid and diff_mask cleared.
  - done=0.
- SWEEP:
  - busy=1; vec_a/vec_b are registered and stable for SETTLE cycles.
  - If settle_cnt!=0: decrement.
  - If settle_cnt==0 (sample edge): compare y_impl vs y_gold.
    - On mismatch: mism_cnt++; diff_mask |= xor.
    - On the first mismatch of the sweep (first_fail_valid==0): first_fail_vec=vec and first_fail_valid=1.
  - At a sample edge, if vec==all-ones: next state DONE, busy=0, done=1, vec holds. Otherwise vec++ and settle_cnt=SETTLE-1.
- start is ignored in SWEEP; a sweep runs to completion.
- Latency:
  - start sampled at edge E0; vector k is sampled at edge E0+(k+1)*SETTLE.
  - done is high after edge E0+2^(WA+WB)*SETTLE; with defaults, after 1024 cycles.
- mism_cnt is WA+WB+1 bits, so it cannot overflow (max 2^(WA+WB)); no saturation logic.
- DONE holds all results and vec stable until start or reset.
- rst_n low mid-sweep: immediate return to IDLE, all results cleared, no partial done.
- X on y_impl/y_gold counts as a mismatch in simulation only; the bench must not drive X.

Decomposition:
- Package eco_sweep_pkg holds:
  - state enum {IDLE, SWEEP, DONE}
  - default width constants WA/WB/WY
  - helper localparam NVEC = 1<<(WA+WB)
- Sub-module eco_mismatch_tracker: combinational xor/compare plus registered mism_cnt, first_fail capture and diff_mask. It has clear and sample_en inputs driven by the FSM.
- Top holds the FSM, vector counter and settle counter.

Test Plan:
- Golden equals impl (both inputs tied to the same model), defaults, start pulse -> busy for 1024 cycles; then done=1, pass=1, mism_cnt=0, first_fail_valid=0, diff_mask=3'b000.
- Golden model flips Y[1] only at vec=10'h155 (A=5'h15, B=5'h0A) -> mism_cnt=1, first_fail_vec=10'h155, diff_mask=3'b010, pass=0.
- y_gold = ~y_impl for every vector -> mism_cnt=1024, first_fail_vec=0, diff_mask=3'b111.
- SETTLE=3, golden equals impl -> each vec_a/vec_b value stable for exactly 3 cycles; done rises 3072 cycles after start.
- Assert rst_n low at vector 300 with 5 mismatches already counted -> all outputs 0 immediately; a later start reruns from vec=0 with mism_cnt starting at 0.
- start pulse mid-sweep is ignored (no counter reset); start in DONE after a failing run clears results and re-sweeps to pass=1 once the models are matched.
